pipeline_hazard_ctrl: RTL and testbench

- Drives the en/clear inputs of every pipeline register in the 5-stage RV32I core: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves three hazard classes: load-use stalls, EX-stage control redirects (branch/jump flush), and fixed-latency data-memory loads that freeze the pipeline.
- Keeps saturating-free performance counters for stall cycles and flush events.
- Sits in the core top beside the forwarding unit.

---
 rtl/core_pkg.sv | 39 +++
 rtl/pipeline_hazard_ctrl_if.sv | 38 +++
 rtl/pipeline_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types: hazard FSM state, per-register pipeline control bundle and
// architectural constants used by the hazard controller.
package core_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hazard_state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_clear;
        logic id_ex_clear;
        logic ex_mem_clear;
        logic mem_wb_clear;
    } pipe_ctrl_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Free-flowing pipeline: every register captures, nothing is squashed.
    function automatic pipe_ctrl_t ctrl_run();
        pipe_ctrl_t c;
        c.pc_en        = 1'b1;
        c.if_id_en     = 1'b1;
        c.id_ex_en     = 1'b1;
        c.ex_mem_en    = 1'b1;
        c.mem_wb_en    = 1'b1;
        c.if_id_clear  = 1'b0;
        c.id_ex_clear  = 1'b0;
        c.ex_mem_clear = 1'b0;
        c.mem_wb_clear = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard sources from the ID/EX/MEM stages and the resulting pipeline-register
// enables/clears. The core side is master, the hazard controller is slave.
interface pipeline_hazard_ctrl_if;

    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       ex_redirect;
    logic       mem_is_load;

    logic       pc_en;
    logic       if_id_en;
    logic       id_ex_en;
    logic       ex_mem_en;
    logic       mem_wb_en;
    logic       if_id_clear;
    logic       id_ex_clear;
    logic       ex_mem_clear;
    logic       mem_wb_clear;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_mem_read, ex_rd, ex_redirect, mem_is_load,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_mem_read, ex_rd, ex_redirect, mem_is_load,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear
    );

endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: load-use stalls,
// EX redirect flushes, multi-cycle load freezes and stall/flush perf counters.
module pipeline_hazard_ctrl
    import core_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_hazard_ctrl_if.slave hz,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_count
);

    localparam bit         MULTI_CYCLE = (LOAD_LAT > 1);
    localparam logic [3:0] WAIT_INIT   = MULTI_CYCLE ? 4'(LOAD_LAT - 2) : 4'd0;

    hazard_state_t state_q, state_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    pipe_ctrl_t    ctrl;

    logic load_start;
    logic freeze;
    logic load_use;
    logic redirect_applied;

    assign load_start = (state_q == RUN) && hz.mem_is_load && MULTI_CYCLE;
    assign freeze     = load_start || ((state_q == MEM_WAIT) && (wait_cnt_q != 4'd0));

    assign load_use = hz.ex_mem_read && (hz.ex_rd != REG_X0) &&
                      ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

    // A redirect seen during a freeze is ignored; EX is held so it re-presents later.
    assign redirect_applied = hz.ex_redirect && !freeze;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (load_start) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_INIT;
                end
            end
            MEM_WAIT: begin
                if (wait_cnt_q != 4'd0) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        ctrl = ctrl_run();
        if (!rst_n) begin
            ctrl.pc_en        = 1'b0;
            ctrl.if_id_en     = 1'b0;
            ctrl.id_ex_en     = 1'b0;
            ctrl.ex_mem_en    = 1'b0;
            ctrl.mem_wb_en    = 1'b0;
            ctrl.if_id_clear  = 1'b1;
            ctrl.id_ex_clear  = 1'b1;
            ctrl.ex_mem_clear = 1'b1;
            ctrl.mem_wb_clear = 1'b1;
        end else if (freeze) begin
            // Hold everything up to MEM; WB receives a bubble each frozen cycle.
            ctrl.pc_en        = 1'b0;
            ctrl.if_id_en     = 1'b0;
            ctrl.id_ex_en     = 1'b0;
            ctrl.ex_mem_en    = 1'b0;
            ctrl.mem_wb_clear = 1'b1;
        end else if (hz.ex_redirect) begin
            ctrl.if_id_clear = 1'b1;
            ctrl.id_ex_clear = 1'b1;
        end else if (load_use) begin
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_en    = 1'b0;
            ctrl.id_ex_clear = 1'b1;
        end
    end

    assign hz.pc_en        = ctrl.pc_en;
    assign hz.if_id_en     = ctrl.if_id_en;
    assign hz.id_ex_en     = ctrl.id_ex_en;
    assign hz.ex_mem_en    = ctrl.ex_mem_en;
    assign hz.mem_wb_en    = ctrl.mem_wb_en;
    assign hz.if_id_clear  = ctrl.if_id_clear;
    assign hz.id_ex_clear  = ctrl.id_ex_clear;
    assign hz.ex_mem_clear = ctrl.ex_mem_clear;
    assign hz.mem_wb_clear = ctrl.mem_wb_clear;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (!ctrl.pc_en) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_count <= '0;
        end else if (redirect_applied) begin
            flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: three instances with LOAD_LAT of 1, 3 and 4.
module tb_pipeline_hazard_ctrl;

    localparam logic [8:0] C_RUN    = 9'b11111_0000;
    localparam logic [8:0] C_RST    = 9'b00000_1111;
    localparam logic [8:0] C_FREEZE = 9'b00001_0001;
    localparam logic [8:0] C_REDIR  = 9'b11111_1100;
    localparam logic [8:0] C_LU     = 9'b00111_0100;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    logic [31:0] stall1, flush1, stall3, flush3, stall4, flush4;

    pipeline_hazard_ctrl_if hz1 ();
    pipeline_hazard_ctrl_if hz3 ();
    pipeline_hazard_ctrl_if hz4 ();

    pipeline_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(32)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .hz(hz1), .stall_cycles(stall1), .flush_count(flush1)
    );
    pipeline_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(32)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .hz(hz3), .stall_cycles(stall3), .flush_count(flush3)
    );
    pipeline_hazard_ctrl #(.LOAD_LAT(4), .CNT_W(32)) u_lat4 (
        .clk(clk), .rst_n(rst_n), .hz(hz4), .stall_cycles(stall4), .flush_count(flush4)
    );

    wire [8:0] c1 = {hz1.pc_en, hz1.if_id_en, hz1.id_ex_en, hz1.ex_mem_en, hz1.mem_wb_en,
                     hz1.if_id_clear, hz1.id_ex_clear, hz1.ex_mem_clear, hz1.mem_wb_clear};
    wire [8:0] c3 = {hz3.pc_en, hz3.if_id_en, hz3.id_ex_en, hz3.ex_mem_en, hz3.mem_wb_en,
                     hz3.if_id_clear, hz3.id_ex_clear, hz3.ex_mem_clear, hz3.mem_wb_clear};
    wire [8:0] c4 = {hz4.pc_en, hz4.if_id_en, hz4.id_ex_en, hz4.ex_mem_en, hz4.mem_wb_en,
                     hz4.if_id_clear, hz4.id_ex_clear, hz4.ex_mem_clear, hz4.mem_wb_clear};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        hz1.id_rs1 = 5'd0; hz1.id_rs2 = 5'd0; hz1.id_use_rs1 = 1'b0; hz1.id_use_rs2 = 1'b0;
        hz1.ex_mem_read = 1'b0; hz1.ex_rd = 5'd0; hz1.ex_redirect = 1'b0; hz1.mem_is_load = 1'b0;
        hz3.id_rs1 = 5'd0; hz3.id_rs2 = 5'd0; hz3.id_use_rs1 = 1'b0; hz3.id_use_rs2 = 1'b0;
        hz3.ex_mem_read = 1'b0; hz3.ex_rd = 5'd0; hz3.ex_redirect = 1'b0; hz3.mem_is_load = 1'b0;
        hz4.id_rs1 = 5'd0; hz4.id_rs2 = 5'd0; hz4.id_use_rs1 = 1'b0; hz4.id_use_rs2 = 1'b0;
        hz4.ex_mem_read = 1'b0; hz4.ex_rd = 5'd0; hz4.ex_redirect = 1'b0; hz4.mem_is_load = 1'b0;
    endtask

    task automatic test_reset();
        idle_all();
        rst_n = 1'b0;
        hz1.mem_is_load = 1'b1;
        hz4.mem_is_load = 1'b1;
        tick();
        tick();
        total_cnt++;
        if (c4 !== C_RST) $display("FAIL reset_ctrl_lat4: got %b want %b", c4, C_RST);
        else pass_cnt++;
        total_cnt++;
        if (c1 !== C_RST) $display("FAIL reset_ctrl_lat1: got %b want %b", c1, C_RST);
        else pass_cnt++;
        idle_all();
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (c4 !== C_RUN) $display("FAIL reset_state_run: got %b want %b", c4, C_RUN);
        else pass_cnt++;
        total_cnt++;
        if ({stall1, flush1, stall3, flush3, stall4, flush4} !== 192'd0)
            $display("FAIL reset_counters: s1=%0d f1=%0d s3=%0d f3=%0d s4=%0d f4=%0d want 0",
                     stall1, flush1, stall3, flush3, stall4, flush4);
        else pass_cnt++;
    endtask

    task automatic test_load_use();
        idle_all();
        hz1.ex_mem_read = 1'b1; hz1.ex_rd = 5'd5; hz1.id_rs2 = 5'd5; hz1.id_use_rs2 = 1'b1;
        hz1.id_rs1 = 5'd3; hz1.id_use_rs1 = 1'b1;
        #1;
        total_cnt++;
        if (c1 !== C_LU) $display("FAIL load_use_rs2: got %b want %b", c1, C_LU);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (stall1 !== 32'd1) $display("FAIL load_use_stall_cnt: got %0d want 1", stall1);
        else pass_cnt++;
        hz1.ex_mem_read = 1'b0;
        #1;
        total_cnt++;
        if (c1 !== C_RUN) $display("FAIL load_use_one_cycle: got %b want %b", c1, C_RUN);
        else pass_cnt++;
        tick();
        hz1.ex_mem_read = 1'b1; hz1.ex_rd = 5'd0; hz1.id_rs2 = 5'd0;
        #1;
        total_cnt++;
        if (c1 !== C_RUN) $display("FAIL load_use_x0: got %b want %b", c1, C_RUN);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (stall1 !== 32'd1) $display("FAIL load_use_x0_cnt: got %0d want 1", stall1);
        else pass_cnt++;
        hz1.ex_rd = 5'd7; hz1.id_rs1 = 5'd7; hz1.id_use_rs1 = 1'b1; hz1.id_rs2 = 5'd2;
        #1;
        total_cnt++;
        if (c1 !== C_LU) $display("FAIL load_use_rs1: got %b want %b", c1, C_LU);
        else pass_cnt++;
        tick();
        hz1.id_use_rs1 = 1'b0;
        #1;
        total_cnt++;
        if (c1 !== C_RUN) $display("FAIL load_use_rs1_unused: got %b want %b", c1, C_RUN);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (stall1 !== 32'd2) $display("FAIL load_use_rs1_cnt: got %0d want 2", stall1);
        else pass_cnt++;
    endtask

    task automatic test_redirect();
        idle_all();
        hz1.ex_mem_read = 1'b1; hz1.ex_rd = 5'd5; hz1.id_rs2 = 5'd5; hz1.id_use_rs2 = 1'b1;
        hz1.ex_redirect = 1'b1;
        #1;
        total_cnt++;
        if (c1 !== C_REDIR) $display("FAIL redirect_over_lu: got %b want %b", c1, C_REDIR);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (flush1 !== 32'd1 || stall1 !== 32'd2)
            $display("FAIL redirect_counters: flush=%0d stall=%0d want flush=1 stall=2",
                     flush1, stall1);
        else pass_cnt++;
        idle_all();
        hz1.mem_is_load = 1'b1;
        #1;
        total_cnt++;
        if (c1 !== C_RUN) $display("FAIL lat1_no_freeze: got %b want %b", c1, C_RUN);
        else pass_cnt++;
        tick();
        hz1.mem_is_load = 1'b0;
        #1;
        total_cnt++;
        if (c1 !== C_RUN || stall1 !== 32'd2)
            $display("FAIL lat1_after_load: ctrl=%b stall=%0d want %b stall=2",
                     c1, stall1, C_RUN);
        else pass_cnt++;
    endtask

    task automatic test_freeze_lat4();
        logic [8:0] exp;
        idle_all();
        hz4.mem_is_load = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            exp = (i < 3) ? C_FREEZE : C_RUN;
            total_cnt++;
            if (c4 !== exp) $display("FAIL freeze_lat4_cycle%0d: got %b want %b", i, c4, exp);
            else pass_cnt++;
            tick();
            hz4.mem_is_load = 1'b0;
        end
        total_cnt++;
        if (stall4 !== 32'd3) $display("FAIL freeze_lat4_stall_cnt: got %0d want 3", stall4);
        else pass_cnt++;
    endtask

    task automatic test_redirect_freeze();
        logic [8:0] exp;
        idle_all();
        hz3.mem_is_load = 1'b1;
        hz3.ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            exp = (i < 2) ? C_FREEZE : C_REDIR;
            total_cnt++;
            if (c3 !== exp) $display("FAIL redir_freeze_cycle%0d: got %b want %b", i, c3, exp);
            else pass_cnt++;
            tick();
            hz3.mem_is_load = 1'b0;
        end
        hz3.ex_redirect = 1'b0;
        total_cnt++;
        if (flush3 !== 32'd1 || stall3 !== 32'd2)
            $display("FAIL redir_freeze_counters: flush=%0d stall=%0d want flush=1 stall=2",
                     flush3, stall3);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp;
        idle_all();
        hz3.mem_is_load = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp = (i == 2 || i == 5) ? C_RUN : C_FREEZE;
            total_cnt++;
            if (c3 !== exp) $display("FAIL back_to_back_cycle%0d: got %b want %b", i, c3, exp);
            else pass_cnt++;
            tick();
        end
        hz3.mem_is_load = 1'b0;
        total_cnt++;
        if (stall3 !== 32'd6) $display("FAIL back_to_back_stall_cnt: got %0d want 6", stall3);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_freeze();
        idle_all();
        hz4.mem_is_load = 1'b1;
        #1;
        total_cnt++;
        if (c4 !== C_FREEZE) $display("FAIL midrst_freeze1: got %b want %b", c4, C_FREEZE);
        else pass_cnt++;
        tick();
        hz4.mem_is_load = 1'b0;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (c4 !== C_RST) $display("FAIL midrst_forced: got %b want %b", c4, C_RST);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (c4 !== C_RUN) $display("FAIL midrst_run: got %b want %b", c4, C_RUN);
        else pass_cnt++;
        total_cnt++;
        if (stall4 !== 32'd0 || flush4 !== 32'd0)
            $display("FAIL midrst_counters: stall=%0d flush=%0d want 0", stall4, flush4);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (c4 !== C_RUN || stall4 !== 32'd0)
            $display("FAIL midrst_stays_run: ctrl=%b stall=%0d want %b stall=0",
                     c4, stall4, C_RUN);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        idle_all();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_redirect();
        test_freeze_lat4();
        test_redirect_freeze();
        test_back_to_back();
        test_reset_mid_freeze();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
